switch_pkt_tx: RTL and testbench

//   Packet transmitter feeding the switch ingress (data_in / sw_enable_in).

---
 rtl/switch_pkt_tx_if.sv | 33 +++
 rtl/switch_pkt_tx.sv | 132 +++++++++++++
 tb/tb_switch_pkt_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/switch_pkt_tx_if.sv
// Signal bundle between the host, switch_pkt_tx and the switch ingress.
// Latency: none (wires only).
// Backpressure: none; the transmitter side (slave) drives status and switch data.
interface switch_pkt_tx_if #(
  parameter int WORD_WIDTH = 8,
  parameter int FIFO_SIZE  = 64
);
  localparam int CW = $clog2(FIFO_SIZE) + 1;

  logic                  pl_wr_en;
  logic [WORD_WIDTH-1:0] pl_wr_data;
  logic                  pl_full;
  logic [CW-1:0]         pl_count;
  logic                  start;
  logic [WORD_WIDTH-1:0] da;
  logic [WORD_WIDTH-1:0] sa;
  logic [WORD_WIDTH-1:0] len;
  logic                  busy;
  logic                  done;
  logic                  err_len;
  logic [WORD_WIDTH-1:0] data_out;
  logic                  sw_enable_out;

  modport master (
    output pl_wr_en, pl_wr_data, start, da, sa, len,
    input  pl_full, pl_count, busy, done, err_len, data_out, sw_enable_out
  );

  modport slave (
    input  pl_wr_en, pl_wr_data, start, da, sa, len,
    output pl_full, pl_count, busy, done, err_len, data_out, sw_enable_out
  );
endinterface

// File: rtl/switch_pkt_tx.sv
// Packet transmitter: buffers host payload words, frames DA,SA,LEN,payload to the switch.
// Latency: start sampled at edge N -> DA on data_out after edge N+1; gap of GAP_CYCLES after each packet.
// Backpressure: none downstream; host pushes into a full FIFO are dropped, start ignored while busy.
module switch_pkt_tx #(
  parameter int WORD_WIDTH = 8,
  parameter int FIFO_SIZE  = 64,
  parameter int GAP_CYCLES = 2
) (
  input logic           clk,
  input logic           rst_n,
  switch_pkt_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_SIZE);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int MW = (WORD_WIDTH > CW) ? WORD_WIDTH : CW;

  typedef enum logic [2:0] {
    S_IDLE, S_DA, S_SA, S_LEN, S_PAYLOAD, S_GAP
  } state_t;

  state_t                state, state_nxt;
  logic [WORD_WIDTH-1:0] da_q, sa_q, len_q, pay_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [WORD_WIDTH-1:0] mem [FIFO_SIZE];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  full, push, pop, len_ok, start_ok, start_bad;
  logic [WORD_WIDTH-1:0] data_q;
  logic                  en_q, done_q, err_q;

  // Payload words only leave the FIFO during PAYLOAD; a pop frees a slot for a same-cycle push.
  assign full      = (count == CW'(FIFO_SIZE));
  assign pop       = (state == S_PAYLOAD);
  assign push      = bus.pl_wr_en && (!full || pop);
  assign len_ok    = (bus.len != '0) && (MW'(bus.len) <= MW'(count));
  assign start_ok  = (state == S_IDLE) && bus.start && len_ok;
  assign start_bad = (state == S_IDLE) && bus.start && !len_ok;

  assign bus.pl_full       = full;
  assign bus.pl_count      = count;
  assign bus.busy          = (state != S_IDLE);
  assign bus.done          = done_q;
  assign bus.err_len       = err_q;
  assign bus.data_out      = data_q;
  assign bus.sw_enable_out = en_q;

  // FIFO storage; not reset, contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.pl_wr_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_SIZE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: fixed header sequence, len payload cycles, then the idle gap.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_ok) state_nxt = S_DA;
      S_DA:      state_nxt = S_SA;
      S_SA:      state_nxt = S_LEN;
      S_LEN:     state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (pay_cnt == WORD_WIDTH'(1)) state_nxt = S_GAP;
      S_GAP:     if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Header latch, payload down-counter and gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      da_q    <= '0;
      sa_q    <= '0;
      len_q   <= '0;
      pay_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (start_ok) begin
        da_q    <= bus.da;
        sa_q    <= bus.sa;
        len_q   <= bus.len;
        pay_cnt <= bus.len;
      end else if (state == S_PAYLOAD) begin
        pay_cnt <= pay_cnt - 1'b1;
      end
      if (state == S_GAP && state_nxt == S_GAP) gap_cnt <= gap_cnt + 1'b1;
      else                                      gap_cnt <= '0;
    end
  end

  // Registered switch outputs and status pulses, one cycle behind the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      en_q   <= (state == S_DA) || (state == S_SA) || (state == S_LEN) || (state == S_PAYLOAD);
      done_q <= (state == S_GAP) && (gap_cnt == '0);
      err_q  <= start_bad;
      case (state)
        S_DA:      data_q <= da_q;
        S_SA:      data_q <= sa_q;
        S_LEN:     data_q <= len_q;
        S_PAYLOAD: data_q <= mem[rd_ptr];
        default:   data_q <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_switch_pkt_tx.sv
// Randomized/directed bench for switch_pkt_tx with a queue-based packet model and scoreboard.
// Latency: stimulus pushes expected bytes at start; monitor pops them as sw_enable_out frames appear.
// Backpressure: none; FIFO overflow and busy-start cases are covered by the model.
module tb_switch_pkt_tx;
  localparam int WW  = 8;
  localparam int FS  = 64;
  localparam int GAP = 2;

  logic clk;
  logic rst_n;
  switch_pkt_tx_if #(.WORD_WIDTH(WW), .FIFO_SIZE(FS)) bus ();

  switch_pkt_tx #(.WORD_WIDTH(WW), .FIFO_SIZE(FS), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WW-1:0] mq[$];     // model of FIFO contents
  logic [WW-1:0] exp_q[$];  // expected bytes on the switch
  int exp_done = 0, act_done = 0, exp_err = 0, act_err = 0;
  int low_run = 0;
  bit check_gap = 0;
  bit prev_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: every framed byte must be the next expected one.
  always @(negedge clk) begin
    logic [WW-1:0] b;
    if (rst_n) begin
      if (bus.sw_enable_out) begin
        if (!prev_en && check_gap) chk("gap_len", low_run, GAP + 1);
        low_run = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", bus.data_out);
        end else begin
          b = exp_q.pop_front();
          chk("data_out", bus.data_out, b);
        end
      end else begin
        low_run++;
        chk("idle_data_zero", bus.data_out, 0);
      end
      if (bus.done)    act_done++;
      if (bus.err_len) act_err++;
    end else begin
      low_run = 0;
    end
    prev_en = bus.sw_enable_out && rst_n;
  end

  task automatic push(input logic [WW-1:0] w);
    bus.pl_wr_en   = 1'b1;
    bus.pl_wr_data = w;
    if (mq.size() < FS) mq.push_back(w);
    @(negedge clk);
    bus.pl_wr_en = 1'b0;
  endtask

  // Model decision: a packet is the first len queued words if 1<=len<=queued.
  task automatic send(input logic [WW-1:0] d, input logic [WW-1:0] s, input logic [WW-1:0] l);
    bus.da = d; bus.sa = s; bus.len = l; bus.start = 1'b1;
    if (l != 0 && int'(l) <= mq.size()) begin
      exp_q.push_back(d); exp_q.push_back(s); exp_q.push_back(l);
      for (int i = 0; i < int'(l); i++) exp_q.push_back(mq.pop_front());
      exp_done++;
    end else begin
      exp_err++;
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (n >= 1000), 0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    rst_n = 1'b0;
    bus.pl_wr_en = 0; bus.pl_wr_data = 0; bus.start = 0;
    bus.da = 0; bus.sa = 0; bus.len = 0;
    repeat (3) @(negedge clk);
    chk("rst_count", bus.pl_count, 0);
    chk("rst_full", bus.pl_full, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_en", bus.sw_enable_out, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err_len, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic packet and latency
    push(8'hA1); push(8'hA2); push(8'hA3);
    chk("t1_count", bus.pl_count, 3);
    send(8'h02, 8'h07, 8'h03);
    chk("t1_busy", bus.busy, 1);
    chk("t1_en_early", bus.sw_enable_out, 0);
    @(negedge clk);
    chk("t1_en_da", bus.sw_enable_out, 1);
    wait_idle();
    chk("t1_count_after", bus.pl_count, 0);

    // 2: rejected starts
    send(8'h01, 8'h01, 8'h01);
    chk("t2_err", bus.err_len, 1);
    chk("t2_busy", bus.busy, 0);
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    send(8'h01, 8'h01, 8'h00);
    chk("t2_err0", bus.err_len, 1);
    chk("t2_busy0", bus.busy, 0);
    send(8'h33, 8'h44, 8'h05);
    wait_idle();

    // 3: full FIFO, overflow drop, len > FIFO_SIZE, pointer wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < FS; i++) push(8'($urandom_range(0, 255)));
      push(8'hEE);
      chk("t3_full", bus.pl_full, 1);
      chk("t3_count", bus.pl_count, mq.size());
      send(8'h05, 8'h06, 8'd65);
      chk("t3_err65", bus.err_len, 1);
      send(8'h05, 8'h06, 8'd64);
      wait_idle();
      chk("t3_empty", bus.pl_count, 0);
    end

    // 4: pushes and start during PAYLOAD
    for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
    send(8'h0A, 8'h0B, 8'h04);
    repeat (3) @(negedge clk);
    bus.pl_wr_en = 1'b1; bus.pl_wr_data = 8'hC1; mq.push_back(8'hC1);
    bus.start = 1'b1; bus.len = 8'h01;
    @(negedge clk);
    bus.pl_wr_data = 8'hC2; mq.push_back(8'hC2); bus.start = 1'b0;
    @(negedge clk);
    bus.pl_wr_en = 1'b0;
    wait_idle();
    chk("t4_count", bus.pl_count, mq.size());

    // 5: reset during SA
    push(8'h61); push(8'h62); push(8'h63);
    send(8'h0C, 8'h0D, 8'h02);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete(); mq.delete(); exp_done--;
    #1;
    chk("t5_en", bus.sw_enable_out, 0);
    chk("t5_data", bus.data_out, 0);
    chk("t5_count", bus.pl_count, mq.size());
    chk("t5_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(8'h71); push(8'h72);
    send(8'h0E, 8'h0F, 8'h02);
    wait_idle();

    // 6: start held high, back-to-back packets
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
    bus.da = 8'h21; bus.sa = 8'h22; bus.len = 8'h02; bus.start = 1'b1;
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back(8'h21); exp_q.push_back(8'h22); exp_q.push_back(8'h02);
      exp_q.push_back(mq.pop_front()); exp_q.push_back(mq.pop_front());
      exp_done++;
    end
    nd = 0;
    for (int n = 0; n < 300 && nd < 4; n++) begin
      @(negedge clk);
      if (bus.done) begin
        nd++;
        if (nd == 1) check_gap = 1;
      end
    end
    bus.start = 1'b0;
    chk("t6_packets", nd, 4);
    wait_idle();
    check_gap = 0;
    chk("t6_count", bus.pl_count, 0);

    // Randomized traffic
    for (int it = 0; it < 25; it++) begin
      int np = $urandom_range(0, 8);
      for (int i = 0; i < np; i++) push(8'($urandom_range(0, 255)));
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 10)));
      wait_idle();
      chk("rnd_count", bus.pl_count, mq.size());
    end

    repeat (6) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    chk("done_count", act_done, exp_done);
    chk("err_count", act_err, exp_err);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
